// File: rtl/cpu_pkg.sv
// Shared pipeline types: datapath width, packed control word, ALUOp encodings
// and the helper that clears side-effect bits for slots that must not retire.
package cpu_pkg;

  localparam int XLEN = 32;

  // ALUOp encodings carried in the control word; decoded by the EX-stage ALU control.
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       funct7_5;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // A write to x0 must never reach the register file. An empty slot must also
  // never touch memory or redirect the front end.
  function automatic ctrl_t sanitize_ctrl(input ctrl_t c, input logic valid,
                                          input logic [4:0] rd);
    ctrl_t r;
    r = c;
    if (!valid || (rd == 5'd0)) begin
      r.reg_write  = 1'b0;
      r.mem_to_reg = 1'b0;
    end
    if (!valid) begin
      r.mem_write = 1'b0;
      r.mem_read  = 1'b0;
      r.branch    = 1'b0;
      r.jump      = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one event per enabled edge until every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and bubble/squash insertion.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  ctrl_t            id_ctrl,
  input  logic [2:0]       id_funct3,
  input  logic             forward1,
  input  logic             forward2,
  input  logic [XLEN-1:0]  forwarddata1,
  input  logic [XLEN-1:0]  forwarddata2,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_redirect,
  output logic             if_id_hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output ctrl_t            ex_ctrl,
  output logic [2:0]       ex_funct3,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [XLEN-1:0] op1_n;
  logic [XLEN-1:0] op2_n;
  ctrl_t           ctrl_n;
  logic            bubble;

  // Operand select, sanitized control and front-end hold; redirect overrides a stall.
  always_comb begin
    op1_n      = forward1 ? forwarddata1 : id_rdata1;
    op2_n      = forward2 ? forwarddata2 : id_rdata2;
    ctrl_n     = sanitize_ctrl(id_ctrl, id_valid, id_rd);
    bubble     = stall | flush;
    if_id_hold = bubble & ~ex_redirect;
  end

  // Pipeline register: squash and bubble both load an empty slot, otherwise capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= CTRL_BUBBLE;
      ex_funct3 <= '0;
    end else if (ex_redirect || bubble) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= CTRL_BUBBLE;
      ex_funct3 <= '0;
    end else begin
      ex_valid  <= id_valid;
      ex_pc     <= id_pc;
      ex_op1    <= op1_n;
      ex_op2    <= op2_n;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_ctrl   <= ctrl_n;
      ex_funct3 <= id_funct3;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_hold),
    .count (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ex_redirect),
    .count (squash_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rdata1, id_rdata2, id_imm, forwarddata1, forwarddata2;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [9:0]       id_ctrl;
  logic [2:0]       id_funct3;
  logic             forward1, forward2, stall, flush, ex_redirect;
  logic             if_id_hold, ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [9:0]       ex_ctrl;
  logic [2:0]       ex_funct3;
  logic [CNT_W-1:0] bubble_cnt, squash_cnt;

  int checks   = 0;
  int failures = 0;

  // Expected EX-side state.
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_op1, m_op2, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [9:0]      m_ctrl;
  logic [2:0]      m_f3;
  int              m_bcnt, m_scnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_funct3(id_funct3),
    .forward1(forward1), .forward2(forward2),
    .forwarddata1(forwarddata1), .forwarddata2(forwarddata2),
    .stall(stall), .flush(flush), .ex_redirect(ex_redirect),
    .if_id_hold(if_id_hold), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3),
    .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_f3 = '0;
  endtask

  // Expected effect of one rising edge given the current inputs.
  task automatic model_edge();
    if (ex_redirect) begin
      model_clear();
      if (m_scnt < CNT_MAX) m_scnt = m_scnt + 1;
    end else if (stall || flush) begin
      model_clear();
      if (m_bcnt < CNT_MAX) m_bcnt = m_bcnt + 1;
    end else begin
      m_valid = id_valid;
      m_pc    = id_pc;
      m_op1   = forward1 ? forwarddata1 : id_rdata1;
      m_op2   = forward2 ? forwarddata2 : id_rdata2;
      m_imm   = id_imm;
      m_rs1   = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_f3    = id_funct3;
      // Bit map: 9 RegWrite, 8 MemtoReg, 7 MemRead, 6 MemWrite, 4 Branch, 0 Jump.
      m_ctrl  = id_ctrl;
      if (!id_valid || id_rd == 0) m_ctrl = m_ctrl & 10'b00_1111_1111;
      if (!id_valid)               m_ctrl = m_ctrl & 10'b11_0010_1110;
    end
  endtask

  task automatic clock_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    id_valid = 1; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_ctrl = '0; id_funct3 = '0;
    forward1 = 0; forward2 = 0; forwarddata1 = '0; forwarddata2 = '0;
    stall = 0; flush = 0; ex_redirect = 0;
  endtask

  task automatic rand_inputs(input int stall_pct, input int redir_pct);
    id_valid     = ($urandom_range(0, 9) != 0);
    id_pc        = $urandom & 32'hFFFF_FFFC;
    id_rs1       = 5'($urandom); id_rs2 = 5'($urandom);
    id_rd        = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    id_rdata1    = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    id_ctrl      = 10'($urandom); id_funct3 = 3'($urandom);
    forward1     = 1'($urandom); forward2 = 1'($urandom);
    forwarddata1 = $urandom; forwarddata2 = $urandom;
    stall        = ($urandom_range(0, 99) < stall_pct);
    flush        = stall;
    ex_redirect  = ($urandom_range(0, 99) < redir_pct);
  endtask

  task automatic test_reset();
    rand_inputs(0, 0);
    id_ctrl = 10'h3FF; id_rd = 5'd3; stall = 1; flush = 1;
    rst_n = 0;
    #2;
    checks++;
    if (if_id_hold !== 1'b1) begin
      failures++; $display("FAIL reset_hold got=%b exp=1", if_id_hold);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_funct3} !== '0) begin
      failures++; $display("FAIL reset_outputs got_pc=%h got_ctrl=%h exp=0", ex_pc, ex_ctrl);
    end
    checks++;
    if (bubble_cnt !== 0 || squash_cnt !== 0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bubble_cnt, squash_cnt);
    end
    model_clear(); m_bcnt = 0; m_scnt = 0;
    @(negedge clk);
    quiet_inputs();
    rst_n = 1;
    id_valid = 1; id_pc = 32'h100;
    clock_edge();
    checks++;
    if (ex_pc !== 32'h100 || ex_valid !== 1'b1) begin
      failures++; $display("FAIL first_load got_pc=%h got_valid=%b exp=00000100/1", ex_pc, ex_valid);
    end
  endtask

  task automatic test_forwarding();
    quiet_inputs();
    id_pc = 32'h104; id_rdata1 = 5; forward1 = 1; forwarddata1 = 32'h55;
    id_rdata2 = 7; forward2 = 0; forwarddata2 = 32'hDEAD;
    clock_edge();
    checks++;
    if (ex_op1 !== 32'h55 || ex_op2 !== 32'd7) begin
      failures++; $display("FAIL forwarding got=%h/%h exp=55/7", ex_op1, ex_op2);
    end
    id_rdata1 = 9; forward1 = 0; id_rdata2 = 3; forward2 = 1; forwarddata2 = 32'hABC;
    clock_edge();
    checks++;
    if (ex_op1 !== 32'd9 || ex_op2 !== 32'hABC) begin
      failures++; $display("FAIL forwarding2 got=%h/%h exp=9/abc", ex_op1, ex_op2);
    end
  endtask

  task automatic test_load_use();
    quiet_inputs();
    id_pc = 32'h200; id_rd = 5'd4; id_ctrl = 10'b10_0000_0000;
    stall = 1; flush = 1;
    #1;
    checks++;
    if (if_id_hold !== 1'b1) begin
      failures++; $display("FAIL loaduse_hold got=%b exp=1", if_id_hold);
    end
    clock_edge();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 10'd0 || bubble_cnt !== 4'd1) begin
      failures++; $display("FAIL loaduse_bubble got v=%b c=%h b=%0d exp 0/0/1", ex_valid, ex_ctrl, bubble_cnt);
    end
    stall = 0; flush = 0;
    clock_edge();
    checks++;
    if (ex_pc !== 32'h200 || ex_valid !== 1'b1 || ex_ctrl !== 10'b10_0000_0000) begin
      failures++; $display("FAIL loaduse_reload got pc=%h v=%b c=%h exp 200/1/200", ex_pc, ex_valid, ex_ctrl);
    end
  endtask

  task automatic test_redirect_vs_stall();
    quiet_inputs();
    id_pc = 32'h300; id_rd = 5'd6; id_ctrl = 10'h3FF;
    stall = 1; flush = 1; ex_redirect = 1;
    #1;
    checks++;
    if (if_id_hold !== 1'b0) begin
      failures++; $display("FAIL redirect_hold got=%b exp=0", if_id_hold);
    end
    clock_edge();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 10'd0 || ex_pc !== '0) begin
      failures++; $display("FAIL redirect_bubble got v=%b c=%h pc=%h exp 0/0/0", ex_valid, ex_ctrl, ex_pc);
    end
    checks++;
    if (squash_cnt !== 4'd1 || bubble_cnt !== 4'd1) begin
      failures++; $display("FAIL redirect_counters got s=%0d b=%0d exp 1/1", squash_cnt, bubble_cnt);
    end
  endtask

  task automatic test_x0_dest();
    quiet_inputs();
    id_rd = 5'd0; id_ctrl = 10'h3FF;
    clock_edge();
    checks++;
    if (ex_ctrl !== 10'h0FF) begin
      failures++; $display("FAIL x0_dest got=%h exp=0ff", ex_ctrl);
    end
    id_valid = 0; id_rd = 5'd5;
    clock_edge();
    checks++;
    if (ex_ctrl !== 10'h02E || ex_valid !== 1'b0) begin
      failures++; $display("FAIL invalid_slot got c=%h v=%b exp 02e/0", ex_ctrl, ex_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs(20, 10);
      #1;
      checks++;
      if (if_id_hold !== ((stall | flush) & ~ex_redirect)) begin
        failures++; $display("FAIL rand_hold i=%0d got=%b", i, if_id_hold);
      end
      clock_edge();
      checks++;
      if ({ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_funct3} !==
          {m_valid, m_pc, m_op1, m_op2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_f3}) begin
        failures++;
        $display("FAIL rand_regs i=%0d got pc=%h op=%h/%h rd=%0d c=%h v=%b exp pc=%h op=%h/%h rd=%0d c=%h v=%b",
                 i, ex_pc, ex_op1, ex_op2, ex_rd, ex_ctrl, ex_valid, m_pc, m_op1, m_op2, m_rd, m_ctrl, m_valid);
      end
      checks++;
      if (int'(bubble_cnt) != m_bcnt || int'(squash_cnt) != m_scnt) begin
        failures++; $display("FAIL rand_counters i=%0d got=%0d/%0d exp=%0d/%0d", i, bubble_cnt, squash_cnt, m_bcnt, m_scnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    quiet_inputs();
    stall = 1; flush = 1;
    repeat (20) clock_edge();
    checks++;
    if (bubble_cnt !== 4'd15) begin
      failures++; $display("FAIL bubble_saturate got=%0d exp=15", bubble_cnt);
    end
    stall = 0; flush = 0; ex_redirect = 1;
    repeat (20) clock_edge();
    checks++;
    if (squash_cnt !== 4'd15) begin
      failures++; $display("FAIL squash_saturate got=%0d exp=15", squash_cnt);
    end
  endtask

  task automatic test_async_reset();
    quiet_inputs();
    id_pc = 32'h400; id_rd = 5'd7; id_ctrl = 10'h3FF; id_rdata1 = 32'h11;
    clock_edge();
    checks++;
    if (ex_pc !== 32'h400 || ex_ctrl !== 10'h3FF) begin
      failures++; $display("FAIL async_preload got pc=%h c=%h exp 400/3ff", ex_pc, ex_ctrl);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, ex_pc, ex_op1, ex_ctrl, ex_rd} !== '0 || bubble_cnt !== 0 || squash_cnt !== 0) begin
      failures++; $display("FAIL async_reset got pc=%h c=%h b=%0d s=%0d exp 0", ex_pc, ex_ctrl, bubble_cnt, squash_cnt);
    end
    model_clear(); m_bcnt = 0; m_scnt = 0;
    @(negedge clk);
    rst_n = 1;
    id_pc = 32'h404;
    clock_edge();
    checks++;
    if (ex_pc !== 32'h404 || ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
      failures++; $display("FAIL post_reset_load got pc=%h v=%b rd=%0d exp 404/1/7", ex_pc, ex_valid, ex_rd);
    end
  endtask

  initial begin
    quiet_inputs();
    rst_n = 1;
    model_clear(); m_bcnt = 0; m_scnt = 0;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_vs_stall();
    test_x0_dest();
    @(negedge clk);
    test_random();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
